des_pass_sequencer: RTL and testbench

Controller that time-shares one DES core (64-bit block, 64-bit key, decrypt flag) to perform either single DES or two-key Triple DES (EDE: K1, K2, K1).
- Sits between the input/entry logic and the DES core.
- Latches the request, drives the core through one or three passes, and hands the result to the display converters with a busy/done handshake.

---
 rtl/des_pkg.sv | 27 ++
 rtl/des_pass_timer.sv | 49 ++++
 rtl/des_pass_sequencer.sv | 110 +++++++++++
 tb/tb_des_pass_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the DES pass sequencer: state encoding,
// pass indices, block width and the default key pair.
package des_pkg;

    localparam int BLK_W = 64;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] pass_t;

    localparam pass_t PASS_SINGLE_LAST = 2'd0;
    localparam pass_t PASS_TRIPLE_LAST = 2'd2;

    localparam logic [BLK_W-1:0] DEFAULT_KEY1 = 64'h133457799BBCDFF1;
    localparam logic [BLK_W-1:0] DEFAULT_KEY2 = 64'h0000000000000000;

    // EDE: the middle pass runs in the opposite direction to the outer two.
    function automatic logic pass_decrypt(input pass_t pass, input logic decrypt);
        return (pass == 2'd1) ? !decrypt : decrypt;
    endfunction

endpackage

// File: rtl/des_pass_timer.sv
// Cycle counter within a core pass plus the pass index, with terminal-count
// flags consumed by the sequencer FSM.
module des_pass_timer
    import des_pkg::*;
#(
    parameter int CORE_LAT = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  run,
    input  pass_t last_pass,
    output pass_t pass,
    output logic  cnt_tc,
    output logic  pass_last
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LAT - 1);

    if (CORE_LAT < 1 || CORE_LAT > 15) begin : g_bad_core_lat
        $error("CORE_LAT must be in 1..15");
    end

    logic [CNT_W-1:0] cnt;

    assign cnt_tc    = (cnt == CNT_LAST);
    assign pass_last = (pass == last_pass);

    // NOTE: non-blocking assignments make every register here sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            pass <= '0;
        end else if (clear) begin
            cnt  <= '0;
            pass <= '0;
        end else if (run) begin
            if (cnt_tc) begin
                cnt <= '0;
                if (!pass_last) begin
                    pass <= pass + 2'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/des_pass_sequencer.sv
// Time-shares one DES core for single DES or two-key EDE Triple DES, with a
// busy/done handshake toward the display logic.
module des_pass_sequencer #(
    parameter int CORE_LAT = 1,
    parameter int BLK_W    = des_pkg::BLK_W
) (
    input  logic             CLOCK_50,
    input  logic             iRST_N,
    input  logic             start,
    input  logic             tdes,
    input  logic             decrypt,
    input  logic [BLK_W-1:0] din,
    input  logic [BLK_W-1:0] key1,
    input  logic [BLK_W-1:0] key2,
    output logic             busy,
    output logic             done,
    output logic [BLK_W-1:0] dout,
    output logic [BLK_W-1:0] core_din,
    output logic [BLK_W-1:0] core_key,
    output logic             core_decrypt,
    input  logic [BLK_W-1:0] core_dout
);

    import des_pkg::*;

    state_t           state;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] key1_q;
    logic [BLK_W-1:0] key2_q;
    logic [BLK_W-1:0] dout_q;
    logic             dec_q;
    logic             tdes_q;
    logic             busy_q;
    logic             done_q;

    pass_t pass;
    pass_t last_pass;
    logic  cnt_tc;
    logic  pass_last;
    logic  accept;

    assign accept    = (state == ST_IDLE) && start;
    assign last_pass = tdes_q ? PASS_TRIPLE_LAST : PASS_SINGLE_LAST;

    des_pass_timer #(
        .CORE_LAT (CORE_LAT)
    ) u_timer (
        .clk       (CLOCK_50),
        .rst_n     (iRST_N),
        .clear     (accept),
        .run       (state == ST_PASS),
        .last_pass (last_pass),
        .pass      (pass),
        .cnt_tc    (cnt_tc),
        .pass_last (pass_last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            state  <= ST_IDLE;
            blk_q  <= '0;
            key1_q <= '0;
            key2_q <= '0;
            dout_q <= '0;
            dec_q  <= 1'b0;
            tdes_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        blk_q  <= din;
                        key1_q <= key1;
                        key2_q <= key2;
                        dec_q  <= decrypt;
                        tdes_q <= tdes;
                        busy_q <= 1'b1;
                        state  <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    // Each pass result becomes the next pass input block.
                    if (cnt_tc) begin
                        blk_q <= core_dout;
                        if (pass_last) begin
                            dout_q <= core_dout;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign core_din     = blk_q;
    assign core_key     = (pass == 2'd1) ? key2_q : key1_q;
    assign core_decrypt = pass_decrypt(pass, dec_q);
    assign busy         = busy_q;
    assign done         = done_q;
    assign dout         = dout_q;

endmodule

// File: tb/tb_des_pass_sequencer.sv
// Bench for des_pass_sequencer: behavioural DES core behind a CORE_LAT=1 and a
// CORE_LAT=3 instance, with a scoreboard of expected results and done cycles.
module tb_des_pass_sequencer;

    import des_pkg::*;

    typedef struct {
        logic [63:0] dout;
        int          cyc;
    } exp_t;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    // One 64-bit word per S-box row, column 0 in the top nibble.
    localparam logic [63:0] SBOX [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] KB  = 64'h0E329232EA6D0D73;

    function automatic logic [63:0] des(input logic [63:0] blk, input logic [63:0] key, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sk [16];
        logic [63:0] ip, pre, res;
        logic [31:0] l, r, f, t, s_out;
        logic [47:0] e;
        logic [5:0]  six;
        int          row, col;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int s = 0; s < SHIFT_T[rnd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sk[rnd][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) ip[63-i] = blk[64-IP_T[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ (dec ? sk[15-rnd] : sk[rnd]);
            for (int s = 0; s < 8; s++) begin
                six = e[47-6*s -: 6];
                row = {six[5], six[0]};
                col = int'(six[4:1]);
                s_out[31-4*s -: 4] = SBOX[s*4+row][63-4*col -: 4];
            end
            for (int i = 0; i < 32; i++) f[31-i] = s_out[32-P_T[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

    function automatic logic [63:0] model(input logic t, input logic dd, input logic [63:0] blk,
                                          input logic [63:0] k1, input logic [63:0] k2);
        if (!t) return des(blk, k1, dd);
        return des(des(des(blk, k1, dd), k2, !dd), k1, dd);
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start3, tdes, decrypt;
    logic [63:0] din, key1, key2;
    logic        busy1, done1, core_dec1, busy3, done3, core_dec3;
    logic [63:0] dout1, core_din1, core_key1, core_dout1;
    logic [63:0] dout3, core_din3, core_key3, core_dout3, pipe_a, pipe_b;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t q1 [$];
    exp_t q3 [$];
    exp_t e1, e3;
    logic [63:0] last1 = '0;

    initial forever #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    des_pass_sequencer #(.CORE_LAT(1), .BLK_W(64)) u_dut1 (
        .CLOCK_50(clk), .iRST_N(rst_n), .start(start1), .tdes(tdes), .decrypt(decrypt),
        .din(din), .key1(key1), .key2(key2), .busy(busy1), .done(done1), .dout(dout1),
        .core_din(core_din1), .core_key(core_key1), .core_decrypt(core_dec1), .core_dout(core_dout1));

    des_pass_sequencer #(.CORE_LAT(3), .BLK_W(64)) u_dut3 (
        .CLOCK_50(clk), .iRST_N(rst_n), .start(start3), .tdes(tdes), .decrypt(decrypt),
        .din(din), .key1(key1), .key2(key2), .busy(busy3), .done(done3), .dout(dout3),
        .core_din(core_din3), .core_key(core_key3), .core_decrypt(core_dec3), .core_dout(core_dout3));

    always_comb core_dout1 = des(core_din1, core_key1, core_dec1);

    // Two register stages after the combinational core give a 3-cycle core.
    always @(posedge clk) begin
        pipe_a <= des(core_din3, core_key3, core_dec3);
        pipe_b <= pipe_a;
    end
    assign core_dout3 = pipe_b;

    // Scoreboard: every done pulse must match the next expected result and cycle.
    initial forever begin
        @(negedge clk);
        if (done1 === 1'b1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL dut1 spurious done at cycle %0d: dout %h, no result expected", cyc, dout1);
            end else begin
                e1 = q1.pop_front();
                if (dout1 !== e1.dout || cyc != e1.cyc) begin
                    miscompares++;
                    $display("FAIL dut1 result: dout %h at cycle %0d, want %h at cycle %0d",
                             dout1, cyc, e1.dout, e1.cyc);
                end
                last1 = e1.dout;
            end
        end
        if (done3 === 1'b1) begin
            vectors++;
            if (q3.size() == 0) begin
                miscompares++;
                $display("FAIL dut3 spurious done at cycle %0d: dout %h, no result expected", cyc, dout3);
            end else begin
                e3 = q3.pop_front();
                if (dout3 !== e3.dout || cyc != e3.cyc) begin
                    miscompares++;
                    $display("FAIL dut3 result: dout %h at cycle %0d, want %h at cycle %0d",
                             dout3, cyc, e3.dout, e3.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int which, input logic [63:0] val, input int at);
        exp_t x;
        x.dout = val;
        x.cyc  = at;
        if (which == 1) q1.push_back(x);
        else q3.push_back(x);
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic launch(input int which, input logic t, input logic dd, input logic [63:0] blk,
                          input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] expv);
        int lat;
        lat = (which == 1) ? 1 : 3;
        step();
        tdes = t; decrypt = dd; din = blk; key1 = k1; key2 = k2;
        if (which == 1) start1 = 1'b1;
        else start3 = 1'b1;
        push(which, expv, cyc + 1 + (t ? 3 : 1) * lat);
        step();
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int budget);
        int n;
        int left;
        n = 0;
        left = (which == 1) ? q1.size() : q3.size();
        while (left != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            left = (which == 1) ? q1.size() : q3.size();
        end
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL dut%0d completion timeout: %0d results outstanding, want 0", which, left);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; tdes = 1'b0; decrypt = 1'b0;
        din = PT; key1 = DEFAULT_KEY1; key2 = KB;
        repeat (2) step();
        @(negedge clk);
        vectors++;
        if ({busy1, done1, core_dec1, busy3, done3} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset flags: busy1/done1/dec1/busy3/done3=%b, want 00000",
                     {busy1, done1, core_dec1, busy3, done3});
        end
        vectors++;
        if ({dout1, core_din1, core_key1} !== 192'b0) begin
            miscompares++;
            $display("FAIL reset dut1 regs: dout %h din %h key %h, want all zero", dout1, core_din1, core_key1);
        end
        vectors++;
        if (dout3 !== 64'b0) begin
            miscompares++;
            $display("FAIL reset dut3 dout: got %h, want 0", dout3);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int busy_cnt;
        launch(1, 1'b0, 1'b0, PT, DEFAULT_KEY1, KB, CT);
        busy_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy1 === 1'b1) busy_cnt++;
        end
        vectors++;
        if (busy_cnt != 2) begin
            miscompares++;
            $display("FAIL single busy width: got %0d cycles, want 2", busy_cnt);
        end
        wait_idle(1, 20);
    endtask

    task automatic test_ede_collapse();
        launch(1, 1'b1, 1'b0, PT, DEFAULT_KEY1, DEFAULT_KEY1, CT);
        wait_idle(1, 20);
        launch(3, 1'b0, 1'b0, PT, DEFAULT_KEY1, KB, CT);
        wait_idle(3, 20);
        launch(3, 1'b1, 1'b0, PT, DEFAULT_KEY1, DEFAULT_KEY1, CT);
        wait_idle(3, 30);
    endtask

    task automatic test_tdes_roundtrip();
        logic [63:0] ct3;
        logic        dd;
        ct3 = model(1'b1, 1'b0, PT, DEFAULT_KEY1, DEFAULT_KEY2);
        for (int k = 0; k < 2; k++) begin
            dd = (k == 1);
            launch(1, 1'b1, dd, (k == 0) ? PT : ct3, DEFAULT_KEY1, DEFAULT_KEY2, (k == 0) ? ct3 : PT);
            for (int p = 0; p < 3; p++) begin
                @(negedge clk);
                vectors++;
                if ({core_key1, core_dec1} !== {((p == 1) ? DEFAULT_KEY2 : DEFAULT_KEY1), ((p == 1) ? !dd : dd)}) begin
                    miscompares++;
                    $display("FAIL tdes dir%0d pass%0d: key %h dec %b, want key %h dec %b", k, p,
                             core_key1, core_dec1, (p == 1) ? DEFAULT_KEY2 : DEFAULT_KEY1, (p == 1) ? !dd : dd);
                end
                if (p == 0) begin
                    vectors++;
                    if (core_din1 !== ((k == 0) ? PT : ct3)) begin
                        miscompares++;
                        $display("FAIL tdes dir%0d core_din: got %h, want %h", k, core_din1, (k == 0) ? PT : ct3);
                    end
                end
            end
            wait_idle(1, 20);
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] prev;
        logic [63:0] expv;
        int          busy_cnt;
        prev = last1;
        expv = model(1'b1, 1'b0, PT ^ 64'hFF, KB, DEFAULT_KEY1);
        launch(1, 1'b1, 1'b0, PT ^ 64'hFF, KB, DEFAULT_KEY1, expv);
        din = 64'hDEADBEEFCAFEF00D;
        key1 = 64'h1111111111111111;
        step();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        @(negedge clk);
        vectors++;
        if (dout1 !== prev) begin
            miscompares++;
            $display("FAIL ignore dout hold: got %h mid-operation, want %h", dout1, prev);
        end
        step();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        busy_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy1 !== 1'b0) busy_cnt++;
        end
        vectors++;
        if (busy_cnt != 0) begin
            miscompares++;
            $display("FAIL ignore start: busy seen %0d cycles after completion, want 0", busy_cnt);
        end
        wait_idle(1, 5);
        vectors++;
        if (dout1 !== expv) begin
            miscompares++;
            $display("FAIL ignore final dout: got %h, want %h", dout1, expv);
        end
    endtask

    task automatic test_reset_abort();
        int busy_cnt;
        launch(1, 1'b1, 1'b0, PT, DEFAULT_KEY1, KB, 64'h0);
        void'(q1.pop_back());
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        last1 = '0;
        @(negedge clk);
        vectors++;
        if ({busy1, done1} !== 2'b00 || dout1 !== 64'b0 || core_din1 !== 64'b0) begin
            miscompares++;
            $display("FAIL abort state: busy %b done %b dout %h din %h, want 0 0 0 0",
                     busy1, done1, dout1, core_din1);
        end
        busy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy1 !== 1'b0) busy_cnt++;
        end
        vectors++;
        if (busy_cnt != 0) begin
            miscompares++;
            $display("FAIL abort busy: high %0d cycles after reset, want 0", busy_cnt);
        end
        launch(1, 1'b0, 1'b0, PT, DEFAULT_KEY1, KB, CT);
        wait_idle(1, 20);
    endtask

    task automatic test_back_to_back();
        logic [63:0] d0, d1, d2;
        int          a;
        d0 = 64'h0000000000000001;
        d1 = 64'hFEDCBA9876543210;
        d2 = 64'h5555AAAA3333CCCC;
        step();
        tdes = 1'b1; decrypt = 1'b0; key1 = DEFAULT_KEY1; key2 = KB; din = d0;
        start1 = 1'b1;
        a = cyc + 1;
        push(1, model(1'b1, 1'b0, d0, DEFAULT_KEY1, KB), a + 3);
        step();
        din = d1;
        push(1, model(1'b1, 1'b0, d1, DEFAULT_KEY1, KB), a + 8);
        repeat (5) step();
        din = d2;
        push(1, model(1'b1, 1'b0, d2, DEFAULT_KEY1, KB), a + 13);
        repeat (5) step();
        start1 = 1'b0;
        din = 64'hBADBADBADBADBAD0;
        wait_idle(1, 30);
        repeat (4) @(negedge clk);
        vectors++;
        if (busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL back-to-back extra operation: busy %b, want 0", busy1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ede_collapse();
        test_tdes_roundtrip();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
